// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add unsigned mantissa multiplier.
// Drives an external W-bit adder each RUN cycle; product = {acc_hi, q}.
module seq_shift_add_mult #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   mant_a,
   input  logic [W-1:0]   mant_b,
   output logic [W-1:0]   add_a,
   output logic [W-1:0]   add_b,
   output logic           add_ci,
   input  logic [W:0]     add_sum,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  m;
   logic [W-1:0]  acc_hi;
   logic [W-1:0]  q;
   logic [CW-1:0] cnt;

   // adder operands: only live while iterating, zero otherwise
   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_ci = 1'b0;
      if (state == RUN) begin
         add_a = acc_hi;
         add_b = q[0] ? m : '0;
      end
   end

   assign product = {acc_hi, q};

   // control FSM and datapath; carry-out shifts into acc_hi msb
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         m      <= '0;
         acc_hi <= '0;
         q      <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  m      <= mant_a;
                  q      <= mant_b;
                  acc_hi <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc_hi <= add_sum[W:1];
               q      <= {add_sum[0], q[W-1:1]};
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: W=4 and W=8 instances,
// behavioural adder, scoreboard of expected products.
module tb_seq_shift_add_mult;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [3:0] add_a4, add_b4;
   logic       add_ci4, busy4, done4;
   logic [4:0] add_sum4;
   logic [7:0] product4;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [7:0]  add_a8, add_b8;
   logic        add_ci8, busy8, done8;
   logic [8:0]  add_sum8;
   logic [15:0] product8;

   assign add_sum4 = {1'b0, add_a4} + {1'b0, add_b4} + 5'(add_ci4);
   assign add_sum8 = {1'b0, add_a8} + {1'b0, add_b8} + 9'(add_ci8);

   seq_shift_add_mult #(.W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .mant_a(a4), .mant_b(b4),
      .add_a(add_a4), .add_b(add_b4), .add_ci(add_ci4),
      .add_sum(add_sum4),
      .busy(busy4), .done(done4), .product(product4)
   );

   seq_shift_add_mult #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .mant_a(a8), .mant_b(b8),
      .add_a(add_a8), .add_b(add_b8), .add_ci(add_ci8),
      .add_sum(add_sum8),
      .busy(busy8), .done(done8), .product(product8)
   );

   int ntests = 0;
   int nfail  = 0;
   int ndone4 = 0;
   int ndone8 = 0;
   bit mon_en = 1'b0;
   logic [7:0]  q4[$];
   logic [15:0] q8[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         chk("add_ci4", 32'(add_ci4), 0);
         chk("add_ci8", 32'(add_ci8), 0);
         if (!busy4) begin
            chk("idle_add_a4", 32'(add_a4), 0);
            chk("idle_add_b4", 32'(add_b4), 0);
         end
         if (!busy8) begin
            chk("idle_add_a8", 32'(add_a8), 0);
            chk("idle_add_b8", 32'(add_b8), 0);
         end
         if (done4) begin
            ndone4++;
            if (q4.size() == 0) chk("spurious_done4", 32'(done4), 0);
            else chk("product4", 32'(product4), 32'(q4.pop_front()));
         end
         if (done8) begin
            ndone8++;
            if (q8.size() == 0) chk("spurious_done8", 32'(done8), 0);
            else chk("product8", 32'(product8), 32'(q8.pop_front()));
         end
      end
   end

   task automatic run4(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp);
      int cyc;
      @(negedge clk);
      a4 = a; b4 = b; start4 = 1'b1;
      q4.push_back(exp);
      @(posedge clk); #2;
      start4 = 1'b0;
      a4 = ~a; b4 = ~b;
      cyc = 1;
      while (1) begin
         chk("busy4_run", 32'(busy4), 1);
         if (done4 || cyc >= 20) break;
         @(posedge clk); #2;
         cyc++;
      end
      chk("latency4", cyc, 5);
      @(posedge clk); #2;
      chk("idle_after4", 32'(busy4), 0);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b);
      int cyc;
      @(negedge clk);
      a8 = a; b8 = b; start8 = 1'b1;
      q8.push_back(16'(a) * 16'(b));
      @(posedge clk); #2;
      start8 = 1'b0;
      a8 = $urandom; b8 = $urandom;
      cyc = 1;
      while (!done8 && cyc < 30) begin
         @(posedge clk); #2;
         cyc++;
      end
      chk("latency8", cyc, 9);
      @(posedge clk); #2;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int cyc;
      int base;
      tbl[0] = '{4'd15, 4'd15, 8'hE1};
      tbl[1] = '{4'd10, 4'd6,  8'h3C};
      tbl[2] = '{4'd0,  4'd13, 8'h00};
      tbl[3] = '{4'd1,  4'd1,  8'h01};
      tbl[4] = '{4'd15, 4'd0,  8'h00};
      tbl[5] = '{4'd15, 4'd1,  8'h0F};
      tbl[6] = '{4'd8,  4'd8,  8'h40};
      tbl[7] = '{4'd9,  4'd14, 8'h7E};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_product4", 32'(product4), 0);
      chk("rst_busy4", 32'(busy4), 0);
      chk("rst_done4", 32'(done4), 0);
      chk("rst_add_a4", 32'(add_a4), 0);
      chk("rst_add_b4", 32'(add_b4), 0);
      chk("rst_add_ci4", 32'(add_ci4), 0);
      chk("rst_product8", 32'(product8), 0);
      mon_en = 1'b1;

      foreach (tbl[i]) run4(tbl[i].a, tbl[i].b, tbl[i].exp);

      // back-to-back with start held high, operands churn every cycle
      base = ndone4;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         a4 = $urandom; b4 = $urandom; start4 = 1'b1;
         if (!busy4) q4.push_back(8'(a4) * 8'(b4));
      end
      @(negedge clk);
      start4 = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      chk("stream_dones", ndone4 - base, 4);
      chk("stream_sb_empty", q4.size(), 0);

      // reset during RUN cycle 2 aborts with no done pulse
      base = ndone4;
      @(negedge clk);
      a4 = 4'd7; b4 = 4'd11; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy4), 0);
      chk("abort_product", 32'(product4), 0);
      chk("abort_done", 32'(done4), 0);
      repeat (8) @(posedge clk);
      #2;
      chk("abort_no_done", ndone4 - base, 0);
      run4(4'd13, 4'd11, 8'h8F);

      // rst and start together: reset wins
      @(negedge clk);
      a4 = 4'd5; b4 = 4'd5; start4 = 1'b1; rst = 1'b1;
      @(negedge clk);
      start4 = 1'b0; rst = 1'b0;
      chk("rst_start_busy", 32'(busy4), 0);
      chk("rst_start_product", 32'(product4), 0);

      // start pulsed during DONE is ignored
      @(negedge clk);
      a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
      q4.push_back(8'd63);
      @(posedge clk); #2;
      start4 = 1'b0;
      cyc = 1;
      while (!done4 && cyc < 20) begin
         @(posedge clk); #2;
         cyc++;
      end
      chk("done_latency", cyc, 5);
      a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
      @(posedge clk); #2;
      start4 = 1'b0;
      chk("done_single_pulse", 32'(done4), 0);
      chk("done_then_idle", 32'(busy4), 0);
      chk("held_product", 32'(product4), 32'd63);
      repeat (3) @(posedge clk);
      #2;
      chk("held_product_later", 32'(product4), 32'd63);
      chk("still_idle", 32'(busy4), 0);

      // exhaustive W=4
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run4(4'(i), 4'(j), 8'(i * j));

      // W=8 corners and random pairs
      run8(8'd255, 8'd255);
      run8(8'd0, 8'd200);
      run8(8'd128, 8'd2);
      for (int i = 0; i < 4000; i++)
         run8(8'($urandom), 8'($urandom));

      repeat (4) @(posedge clk);
      #2;
      chk("sb4_empty", q4.size(), 0);
      chk("sb8_empty", q8.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
